// File: rtl/sram_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
// No logic. Holds the FSM state encoding, the wait-counter width
// and a helper that turns an access length in cycles into a counter preload.
package sram_pkg;

    // The wait counter is 4 bits wide, so access lengths are 1..15 cycles.
    localparam int WAIT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RD_WAIT,
        WR_PULSE,
        WR_HOLD
    } state_t;

    // Counter preload for a phase lasting 'cycles' clocks.
    // The counter counts down to 0, so the last cycle of the phase is the one that sees zero.
    function automatic logic [WAIT_W-1:0] wait_load(input int cycles);
        return WAIT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Down-counter that times both the read access and the write strobe phases.
// Latency: a load takes effect on the next edge, and zero is a decode of the count register.
// Backpressure: none. The counter decrements only on request and holds at zero instead of wrapping.
module sram_wait_cnt
    import sram_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [WAIT_W-1:0] cnt;

    // Load takes priority over decrement; decrementing at zero is a no-op.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller. Every pin is driven from a flop.
// Latency: a read returns rvalid WAIT_RD+2 cycles after accept; a write gives wdone WAIT_WR+3 cycles after accept.
// Backpressure: ready is high only while idle. A req seen while busy is dropped, not queued.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,   // 8, 16, 24 or 32
    parameter int WAIT_RD = 1,    // 1..15
    parameter int WAIT_WR = 1     // 1..15
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic                ready,
    output logic                rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                wdone,
    output logic [ADDR_W-1:0]   sram_a,
    output logic [DATA_W-1:0]   sram_dq_out,
    output logic                sram_dq_oe,
    input  logic [DATA_W-1:0]   sram_dq_in,
    output logic                CE_n,
    output logic                OE_n,
    output logic                WE_n,
    output logic [DATA_W/8-1:0] BE_n
);

    localparam int                BE_W    = DATA_W / 8;
    localparam logic [WAIT_W-1:0] RD_LOAD = wait_load(WAIT_RD);
    localparam logic [WAIT_W-1:0] WR_LOAD = wait_load(WAIT_WR);

    state_t            state;
    logic              we_q;
    logic [BE_W-1:0]   be_q;

    logic              cnt_load;
    logic [WAIT_W-1:0] cnt_val;
    logic              cnt_dec;
    logic              cnt_zero;

    // The counter is preloaded on the edge that leaves SETUP.
    // The RD_WAIT or WR_PULSE phase then lasts exactly WAIT cycles.
    assign cnt_load = (state == SETUP);
    assign cnt_val  = we_q ? WR_LOAD : RD_LOAD;
    assign cnt_dec  = (state == RD_WAIT) || (state == WR_PULSE);

    sram_wait_cnt u_wait_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // ready is a decode of the state flop only, so it never has a path from the host inputs.
    assign ready = (state == IDLE);

    // Transaction FSM. The pin values for the next cycle are computed alongside the state,
    // so every strobe, address and data pin comes straight from a flop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            be_q        <= '0;
            sram_a      <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            CE_n        <= 1'b1;
            OE_n        <= 1'b1;
            WE_n        <= 1'b1;
            BE_n        <= '1;
            rvalid      <= 1'b0;
            wdone       <= 1'b0;
            rdata       <= '0;
        end else begin
            rvalid <= 1'b0;
            wdone  <= 1'b0;
            case (state)
                IDLE: begin
                    // Accept: latch the request. Host inputs are not looked at again until the next IDLE.
                    if (req) begin
                        we_q   <= we;
                        be_q   <= be;
                        sram_a <= addr;
                        CE_n   <= 1'b0;
                        if (we) begin
                            sram_dq_out <= wdata;
                            sram_dq_oe  <= 1'b1;
                            BE_n        <= ~be;
                        end else begin
                            OE_n <= 1'b0;
                            BE_n <= '0;
                        end
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    // WE_n drops only if at least one lane is enabled.
                    // An all-zero be still walks through the same phases.
                    if (we_q) begin
                        WE_n  <= ~(|be_q);
                        state <= WR_PULSE;
                    end else begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cnt_zero) begin
                        rdata  <= sram_dq_in;
                        rvalid <= 1'b1;
                        CE_n   <= 1'b1;
                        OE_n   <= 1'b1;
                        BE_n   <= '1;
                        state  <= IDLE;
                    end
                end
                WR_PULSE: begin
                    if (cnt_zero) begin
                        WE_n  <= 1'b1;
                        state <= WR_HOLD;
                    end
                end
                WR_HOLD: begin
                    // The address and data were held through this cycle. Release the bus now.
                    CE_n       <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    BE_n       <= '1;
                    wdone      <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    CE_n       <= 1'b1;
                    OE_n       <= 1'b1;
                    WE_n       <= 1'b1;
                    BE_n       <= '1;
                    sram_dq_oe <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl. It uses two instances: the default timing, and WAIT_RD=3 / WAIT_WR=4.
// Each instance drives its own behavioural SRAM. A scoreboard with byte merging supplies expected read data.
// Latencies are predicted from the access-length parameters alone.
module tb_sram_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req, we;
    logic [15:0] addr, wdata;
    logic [1:0]  be;
    bit          sel;

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    // Instance 1: default timing
    logic        ready1, rvalid1, wdone1, dqoe1, ce1, oe1, wen1;
    logic [15:0] rdata1, a1, dqo1, din1;
    logic [1:0]  ben1;
    // Instance 2: slow timing
    logic        ready2, rvalid2, wdone2, dqoe2, ce2, oe2, wen2;
    logic [15:0] rdata2, a2, dqo2, din2;
    logic [1:0]  ben2;

    logic req1, req2;
    assign req1 = req & ~sel;
    assign req2 = req & sel;

    sram_ctrl u_dut1 (
        .CLK(CLK), .RST(RST), .req(req1), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(ready1), .rvalid(rvalid1), .rdata(rdata1), .wdone(wdone1), .sram_a(a1),
        .sram_dq_out(dqo1), .sram_dq_oe(dqoe1), .sram_dq_in(din1),
        .CE_n(ce1), .OE_n(oe1), .WE_n(wen1), .BE_n(ben1)
    );

    sram_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_RD(3), .WAIT_WR(4)) u_dut2 (
        .CLK(CLK), .RST(RST), .req(req2), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(ready2), .rvalid(rvalid2), .rdata(rdata2), .wdone(wdone2), .sram_a(a2),
        .sram_dq_out(dqo2), .sram_dq_oe(dqoe2), .sram_dq_in(din2),
        .CE_n(ce2), .OE_n(oe2), .WE_n(wen2), .BE_n(ben2)
    );

    // Behavioural SRAMs: writes while CE_n and WE_n are both low; reads drive data only while CE_n and OE_n are both low.
    logic [15:0] sram_mem [0:1][0:4095];
    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 4096; i++) begin
                sram_mem[0][i] <= 16'h0000;
                sram_mem[1][i] <= 16'h0000;
            end
        end else begin
            if (!ce1 && !wen1) begin
                if (!ben1[0]) sram_mem[0][a1[11:0]][7:0]  <= dqo1[7:0];
                if (!ben1[1]) sram_mem[0][a1[11:0]][15:8] <= dqo1[15:8];
            end
            if (!ce2 && !wen2) begin
                if (!ben2[0]) sram_mem[1][a2[11:0]][7:0]  <= dqo2[7:0];
                if (!ben2[1]) sram_mem[1][a2[11:0]][15:8] <= dqo2[15:8];
            end
        end
    end
    assign din1 = (!ce1 && !oe1) ? sram_mem[0][a1[11:0]] : 16'hDEAD;
    assign din2 = (!ce2 && !oe2) ? sram_mem[1][a2[11:0]] : 16'hDEAD;

    // Monitor view of whichever instance is selected
    logic        m_ready, m_rvalid, m_wdone, m_dqoe, m_ce, m_oe, m_we;
    logic [15:0] m_rdata, m_a, m_dqo;
    logic [1:0]  m_ben;
    assign m_ready  = sel ? ready2  : ready1;
    assign m_rvalid = sel ? rvalid2 : rvalid1;
    assign m_wdone  = sel ? wdone2  : wdone1;
    assign m_dqoe   = sel ? dqoe2   : dqoe1;
    assign m_ce     = sel ? ce2     : ce1;
    assign m_oe     = sel ? oe2     : oe1;
    assign m_we     = sel ? wen2    : wen1;
    assign m_rdata  = sel ? rdata2  : rdata1;
    assign m_a      = sel ? a2      : a1;
    assign m_dqo    = sel ? dqo2    : dqo1;
    assign m_ben    = sel ? ben2    : ben1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Runs one transaction on the selected instance, starting and ending at a negedge.
    // While the controller is busy, garbage is driven on the host inputs; req is held high if 'hold' is set, random otherwise.
    task automatic do_txn(input bit t_we, input logic [15:0] t_addr, input logic [15:0] t_wdata,
                          input logic [1:0] t_be, input bit hold,
                          output int done_cyc, output logic [15:0] rd, output int we_low,
                          output int we_first, output int oe_low, output logic [1:0] be_setup,
                          output bit inv_ok, output int acc_wait);
        done_cyc = -1; rd = 16'h0; we_low = 0; we_first = -1; oe_low = 0;
        be_setup = 2'b00; inv_ok = 1'b1; acc_wait = 0;
        while (!m_ready && acc_wait < 40) begin
            @(negedge CLK);
            acc_wait++;
        end
        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; be = t_be;
        @(posedge CLK);
        for (int k = 1; k <= 40 && done_cyc < 0; k++) begin
            @(negedge CLK);
            if ((!m_oe && !m_we) || (m_dqoe && !m_oe)) inv_ok = 1'b0;
            if (m_rvalid || m_wdone) begin
                done_cyc = k;
                rd = m_rdata;
                if (!m_ready) inv_ok = 1'b0;
                if (t_we ? m_rvalid : m_wdone) inv_ok = 1'b0;
                if (!m_ce || !m_oe || !m_we || m_ben != 2'b11 || m_dqoe) inv_ok = 1'b0;
            end else begin
                if (m_ready || m_ce || m_a != t_addr) inv_ok = 1'b0;
                if (t_we) begin
                    if (!m_dqoe || !m_oe || m_ben != ~t_be || m_dqo != t_wdata) inv_ok = 1'b0;
                end else begin
                    if (m_dqoe || !m_we || m_ben != 2'b00) inv_ok = 1'b0;
                end
                if (!m_we) begin
                    we_low++;
                    if (we_first < 0) we_first = k;
                end
                if (!m_oe) oe_low++;
                if (k == 1) be_setup = m_ben;
                we = 1'($urandom); addr = 16'($urandom); wdata = 16'($urandom); be = 2'($urandom);
                req = hold ? 1'b1 : 1'($urandom);
            end
        end
        req = 1'b0;
    endtask

    typedef struct {
        bit          t_we;
        logic [15:0] t_addr;
        logic [15:0] t_wdata;
        logic [1:0]  t_be;
        int          exp_done;
        logic [15:0] exp_rdata;
        int          exp_we_low;
        logic [1:0]  exp_be_n;
        int          exp_oe_low;
    } vec_t;

    vec_t        vecs [8];
    logic [15:0] ref_mem [0:1][0:31];
    int          d, wl, wf, ol, aw, wd_seen;
    logic [15:0] rd, exp_rd;
    logic [1:0]  bs;
    bit          ok;

    initial begin
        // Default timing: write takes 4 cycles to wdone, read takes 3 cycles to rvalid.
        vecs[0] = '{1'b1, 16'h1234, 16'hBEEF, 2'b11, 4, 16'h0000, 1, 2'b00, 0};
        vecs[1] = '{1'b0, 16'h1234, 16'h0000, 2'b00, 3, 16'hBEEF, 0, 2'b00, 2};
        vecs[2] = '{1'b1, 16'h0010, 16'hAA55, 2'b01, 4, 16'h0000, 1, 2'b10, 0};
        vecs[3] = '{1'b0, 16'h0010, 16'h0000, 2'b00, 3, 16'h0055, 0, 2'b00, 2};
        vecs[4] = '{1'b1, 16'h0020, 16'h1111, 2'b00, 4, 16'h0000, 0, 2'b11, 0};
        vecs[5] = '{1'b0, 16'h0020, 16'h0000, 2'b00, 3, 16'h0000, 0, 2'b00, 2};
        vecs[6] = '{1'b1, 16'h0010, 16'h3300, 2'b10, 4, 16'h0000, 1, 2'b01, 0};
        vecs[7] = '{1'b0, 16'h0010, 16'h0000, 2'b00, 3, 16'h3355, 0, 2'b00, 2};

        RST = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; sel = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_ce_n", 32'(m_ce), 32'd1);
        check("rst_oe_n", 32'(m_oe), 32'd1);
        check("rst_we_n", 32'(m_we), 32'd1);
        check("rst_be_n", 32'(m_ben), 32'd3);
        check("rst_dq_oe", 32'(m_dqoe), 32'd0);
        check("rst_rvalid", 32'(m_rvalid), 32'd0);
        check("rst_wdone", 32'(m_wdone), 32'd0);
        check("rst_rdata", 32'(m_rdata), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("ready_after_rst", 32'(m_ready), 32'd1);

        // Table-driven directed vectors on the default instance
        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].t_we, vecs[i].t_addr, vecs[i].t_wdata, vecs[i].t_be, 1'b0,
                   d, rd, wl, wf, ol, bs, ok, aw);
            check($sformatf("vec%0d_done", i), 32'(d), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d_pins", i), 32'(ok), 32'd1);
            if (vecs[i].t_we) begin
                check($sformatf("vec%0d_we_low", i), 32'(wl), 32'(vecs[i].exp_we_low));
                check($sformatf("vec%0d_be_n", i), 32'(bs), 32'(vecs[i].exp_be_n));
                if (vecs[i].exp_we_low > 0) check($sformatf("vec%0d_we_first", i), 32'(wf), 32'd2);
            end else begin
                check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
                check($sformatf("vec%0d_oe_low", i), 32'(ol), 32'(vecs[i].exp_oe_low));
            end
        end

        // Slow instance: a write, then two reads with req held high throughout
        sel = 1'b1;
        do_txn(1'b1, 16'h0042, 16'hCAFE, 2'b11, 1'b1, d, rd, wl, wf, ol, bs, ok, aw);
        check("slow_wr_done", 32'(d), 32'd7);
        check("slow_wr_we_low", 32'(wl), 32'd4);
        check("slow_wr_pins", 32'(ok), 32'd1);
        for (int j = 0; j < 2; j++) begin
            do_txn(1'b0, 16'h0042, 16'h0000, 2'b00, 1'b1, d, rd, wl, wf, ol, bs, ok, aw);
            check("slow_rd_accept_wait", 32'(aw), 32'd0);
            check("slow_rd_done", 32'(d), 32'd5);
            check("slow_rd_rdata", 32'(rd), 32'hCAFE);
            check("slow_rd_oe_low", 32'(ol), 32'd4);
        end

        // Reset during cycle 2 of a write on the default instance
        sel = 1'b0;
        req = 1'b1; we = 1'b1; addr = 16'h0FFF; wdata = 16'h1234; be = 2'b11;
        @(posedge CLK);
        @(negedge CLK);
        req = 1'b0;
        @(negedge CLK);
        check("abort_we_low_c2", 32'(m_we), 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        check("abort_strobes", 32'({m_ce, m_oe, m_we, m_ben}), 32'h1F);
        check("abort_dq_oe", 32'(m_dqoe), 32'd0);
        wd_seen = 32'(m_wdone);
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            wd_seen += 32'(m_wdone);
        end
        check("abort_no_wdone", 32'(wd_seen), 32'd0);
        check("abort_ready", 32'(m_ready), 32'd1);

        // Random traffic against the scoreboard
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 32; a++) ref_mem[s][a] = 16'h0000;
        for (int n = 0; n < 1000; n++) begin
            bit          r_we;
            logic [4:0]  r_off;
            logic [15:0] r_wd;
            logic [1:0]  r_be;
            int          rdw, wrw;
            sel   = 1'($urandom);
            r_we  = 1'($urandom);
            r_off = 5'($urandom);
            r_wd  = 16'($urandom);
            r_be  = 2'($urandom);
            rdw   = sel ? 3 : 1;
            wrw   = sel ? 4 : 1;
            exp_rd = ref_mem[sel][r_off];
            do_txn(r_we, {11'h008, r_off}, r_wd, r_be, 1'($urandom), d, rd, wl, wf, ol, bs, ok, aw);
            check("rnd_accept_wait", 32'(aw), 32'd0);
            check("rnd_pins", 32'(ok), 32'd1);
            if (r_we) begin
                check("rnd_wr_done", 32'(d), 32'(wrw + 3));
                check("rnd_wr_we_low", 32'(wl), (r_be != 2'b00) ? 32'(wrw) : 32'd0);
                if (r_be[0]) ref_mem[sel][r_off][7:0]  = r_wd[7:0];
                if (r_be[1]) ref_mem[sel][r_off][15:8] = r_wd[15:8];
            end else begin
                check("rnd_rd_done", 32'(d), 32'(rdw + 2));
                check("rnd_rd_oe_low", 32'(ol), 32'(rdw + 1));
                check("rnd_rd_data", 32'(rd), 32'(exp_rd));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
